// File: rtl/vx_raster_tbuf_writer_pkg.sv
// Shared raster tile-buffer definitions: writer FSM states and header word layout
// (the layout is also decoded by the raster memory fetch unit).
package vx_raster_tbuf_writer_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StPids,
    StHdr0,
    StHdr1,
    StDone
  } tbuf_wr_state_e;

  localparam int unsigned TBUF_HEADER_SIZEW = 2;

  localparam int unsigned HDR_FIELD_W         = 16;
  localparam int unsigned HDR_POS_X_LSB       = 0;
  localparam int unsigned HDR_POS_Y_LSB       = 16;
  localparam int unsigned HDR_PIDS_OFFSET_LSB = 0;
  localparam int unsigned HDR_PIDS_COUNT_LSB  = 16;

  function automatic logic [31:0] pack_hdr0(input logic [HDR_FIELD_W-1:0] pos_x,
                                            input logic [HDR_FIELD_W-1:0] pos_y);
    logic [31:0] w;
    w = '0;
    w[HDR_POS_X_LSB +: HDR_FIELD_W] = pos_x;
    w[HDR_POS_Y_LSB +: HDR_FIELD_W] = pos_y;
    return w;
  endfunction

  function automatic logic [31:0] pack_hdr1(input logic [HDR_FIELD_W-1:0] pids_offset,
                                            input logic [HDR_FIELD_W-1:0] pids_count);
    logic [31:0] w;
    w = '0;
    w[HDR_PIDS_OFFSET_LSB +: HDR_FIELD_W] = pids_offset;
    w[HDR_PIDS_COUNT_LSB +: HDR_FIELD_W]  = pids_count;
    return w;
  endfunction

endpackage

// File: rtl/vx_raster_tbuf_writer_hdr_gen.sv
// Combinational header word build, PID-list offset computation and overflow detection.
// The offset is relative to the word after header word 1, as the fetch unit expects.
module vx_raster_tbuf_writer_hdr_gen
  import vx_raster_tbuf_writer_pkg::*;
#(
  parameter int unsigned ADDR_W = 30
) (
  input  logic [ADDR_W-1:0] hdr_addr_i,
  input  logic [ADDR_W-1:0] pid_start_i,
  input  logic [15:0]       cur_x_i,
  input  logic [15:0]       cur_y_i,
  input  logic [15:0]       cur_count_i,
  input  logic [15:0]       tile_count_i,
  input  logic [15:0]       max_tiles_i,
  output logic [31:0]       hdr0_data_o,
  output logic [31:0]       hdr1_data_o,
  output logic [15:0]       count_inc_o,
  output logic              count_wrap_o,
  output logic              ofs_ovf_o,
  output logic              tiles_full_o
);

  logic [ADDR_W-1:0] ofs_full;

  always_comb begin
    ofs_full     = pid_start_i - (hdr_addr_i + ADDR_W'(1)) - ADDR_W'(1);
    hdr0_data_o  = pack_hdr0(cur_x_i, cur_y_i);
    hdr1_data_o  = pack_hdr1(ofs_full[15:0], cur_count_i);
    // Any bit above the 16-bit field (including a negative offset) is lost in the header.
    ofs_ovf_o    = |ofs_full[ADDR_W-1:16];
    {count_wrap_o, count_inc_o} = {1'b0, cur_count_i} + 17'd1;
    tiles_full_o = (tile_count_i == max_tiles_i);
  end

endmodule

// File: rtl/vx_raster_tbuf_writer.sv
// Tile-buffer writer: streams PIDs straight to memory, then emits the 2-word tile header.
// Define RASTER_TBUF_OVF_CHECK_EN to enable overflow/protocol error flagging and tile drop.
module vx_raster_tbuf_writer
  import vx_raster_tbuf_writer_pkg::*;
#(
  parameter string       INSTANCE_ID  = "",
  parameter int unsigned TILE_LOGSIZE = 5,
  parameter int unsigned ADDR_W       = 30
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [ADDR_W-1:0] tbuf_addr,
  input  logic [15:0]       max_tiles,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              in_sop,
  input  logic              in_eop,
  input  logic [15:0]       in_xloc,
  input  logic [15:0]       in_yloc,
  input  logic [31:0]       in_pid,
  output logic              mem_req_valid,
  input  logic              mem_req_ready,
  output logic [ADDR_W-1:0] mem_req_addr,
  output logic [31:0]       mem_req_data,
  output logic              busy,
  output logic              done,
  output logic [15:0]       tile_count,
  output logic              error
);

`ifdef RASTER_TBUF_OVF_CHECK_EN
  localparam bit OvfEn = 1'b1;
`else
  localparam bit OvfEn = 1'b0;
`endif

  tbuf_wr_state_e    state_q, state_d;
  logic [ADDR_W-1:0] hdr_addr_q, hdr_addr_d;
  logic [ADDR_W-1:0] pid_addr_q, pid_addr_d;
  logic [ADDR_W-1:0] pid_start_q, pid_start_d;
  logic [15:0]       cur_x_q, cur_x_d;
  logic [15:0]       cur_y_q, cur_y_d;
  logic [15:0]       cur_count_q, cur_count_d;
  logic [15:0]       max_tiles_q, max_tiles_d;
  logic [15:0]       tile_count_q, tile_count_d;
  logic              tile_open_q, tile_open_d;
  logic              drop_q, drop_d;
  logic              error_q, error_d;

  logic [31:0] hdr0_data, hdr1_data;
  logic [15:0] count_inc;
  logic        count_wrap, ofs_ovf, tiles_full;
  logic        pid_fire, drop_pid, err_set, clr_err;

  vx_raster_tbuf_writer_hdr_gen #(
    .ADDR_W (ADDR_W)
  ) u_hdr_gen (
    .hdr_addr_i   (hdr_addr_q),
    .pid_start_i  (pid_start_q),
    .cur_x_i      (cur_x_q),
    .cur_y_i      (cur_y_q),
    .cur_count_i  (cur_count_q),
    .tile_count_i (tile_count_q),
    .max_tiles_i  (max_tiles_q),
    .hdr0_data_o  (hdr0_data),
    .hdr1_data_o  (hdr1_data),
    .count_inc_o  (count_inc),
    .count_wrap_o (count_wrap),
    .ofs_ovf_o    (ofs_ovf),
    .tiles_full_o (tiles_full)
  );

  // A sop re-evaluates the drop decision; other PIDs inherit it from their open tile.
  always_comb begin
    drop_pid = OvfEn && (in_sop ? tiles_full : (tile_open_q && drop_q));
    pid_fire = (state_q == StPids) && in_valid && mem_req_ready;
  end

  always_comb begin
    in_ready      = 1'b0;
    mem_req_valid = 1'b0;
    mem_req_addr  = pid_addr_q;
    mem_req_data  = in_pid;
    unique case (state_q)
      StPids: begin
        in_ready      = mem_req_ready;
        mem_req_valid = in_valid && !drop_pid;
      end
      StHdr0: begin
        mem_req_valid = 1'b1;
        mem_req_addr  = hdr_addr_q;
        mem_req_data  = hdr0_data;
      end
      StHdr1: begin
        mem_req_valid = 1'b1;
        mem_req_addr  = hdr_addr_q + ADDR_W'(1);
        mem_req_data  = hdr1_data;
      end
      default: ;
    endcase
    busy       = (state_q != StIdle);
    done       = (state_q == StDone);
    tile_count = tile_count_q;
    error      = error_q;
  end

  always_comb begin
    state_d      = state_q;
    hdr_addr_d   = hdr_addr_q;
    pid_addr_d   = pid_addr_q;
    pid_start_d  = pid_start_q;
    cur_x_d      = cur_x_q;
    cur_y_d      = cur_y_q;
    cur_count_d  = cur_count_q;
    max_tiles_d  = max_tiles_q;
    tile_count_d = tile_count_q;
    tile_open_d  = tile_open_q;
    drop_d       = drop_q;
    err_set      = 1'b0;
    clr_err      = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          state_d      = StPids;
          hdr_addr_d   = tbuf_addr;
          pid_addr_d   = tbuf_addr + ADDR_W'(max_tiles) * ADDR_W'(TBUF_HEADER_SIZEW);
          max_tiles_d  = max_tiles;
          tile_count_d = '0;
          tile_open_d  = 1'b0;
          drop_d       = 1'b0;
          clr_err      = 1'b1;
        end
      end
      StPids: begin
        if (pid_fire) begin
          if (!drop_pid) begin
            pid_addr_d = pid_addr_q + ADDR_W'(1);
          end
          if (in_sop) begin
            err_set     = tile_open_q;
            cur_x_d     = in_xloc >> TILE_LOGSIZE;
            cur_y_d     = in_yloc >> TILE_LOGSIZE;
            pid_start_d = pid_addr_q;
            cur_count_d = 16'd1;
            tile_open_d = 1'b1;
            drop_d      = drop_pid;
          end else if (tile_open_q) begin
            cur_count_d = count_inc;
            err_set     = count_wrap && !drop_q;
          end else begin
            // Orphan PID: written, but no tile is opened for it.
            err_set = 1'b1;
          end
          if (in_eop && (in_sop || tile_open_q)) begin
            tile_open_d = 1'b0;
            if (drop_pid) begin
              err_set = 1'b1;
            end else begin
              state_d = StHdr0;
            end
          end
        end else if (!in_valid && !tile_open_q && flush) begin
          state_d = StDone;
        end
      end
      StHdr0: begin
        if (mem_req_ready) begin
          state_d = StHdr1;
        end
      end
      StHdr1: begin
        if (mem_req_ready) begin
          hdr_addr_d   = hdr_addr_q + ADDR_W'(TBUF_HEADER_SIZEW);
          tile_count_d = tile_count_q + 16'd1;
          err_set      = ofs_ovf;
          state_d      = StPids;
        end
      end
      StDone: state_d = StIdle;
      default: state_d = StIdle;
    endcase
    error_d = clr_err ? 1'b0 : (error_q | (OvfEn & err_set));
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q      <= StIdle;
      hdr_addr_q   <= '0;
      pid_addr_q   <= '0;
      pid_start_q  <= '0;
      cur_x_q      <= '0;
      cur_y_q      <= '0;
      cur_count_q  <= '0;
      max_tiles_q  <= '0;
      tile_count_q <= '0;
      tile_open_q  <= 1'b0;
      drop_q       <= 1'b0;
      error_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      hdr_addr_q   <= hdr_addr_d;
      pid_addr_q   <= pid_addr_d;
      pid_start_q  <= pid_start_d;
      cur_x_q      <= cur_x_d;
      cur_y_q      <= cur_y_d;
      cur_count_q  <= cur_count_d;
      max_tiles_q  <= max_tiles_d;
      tile_count_q <= tile_count_d;
      tile_open_q  <= tile_open_d;
      drop_q       <= drop_d;
      error_q      <= error_d;
    end
  end

endmodule

// File: tb/tb_vx_raster_tbuf_writer.sv
// Scoreboard bench for vx_raster_tbuf_writer: directed frames push expected memory writes,
// an independent monitor pops and compares every accepted write.
module tb_vx_raster_tbuf_writer;

  localparam int unsigned ADDR_W = 30;

  logic              clk = 1'b0;
  logic              reset;
  logic              start;
  logic [ADDR_W-1:0] tbuf_addr;
  logic [15:0]       max_tiles;
  logic              flush;
  logic              in_valid;
  logic              in_ready;
  logic              in_sop;
  logic              in_eop;
  logic [15:0]       in_xloc;
  logic [15:0]       in_yloc;
  logic [31:0]       in_pid;
  logic              mem_req_valid;
  logic              mem_req_ready;
  logic [ADDR_W-1:0] mem_req_addr;
  logic [31:0]       mem_req_data;
  logic              busy;
  logic              done;
  logic [15:0]       tile_count;
  logic              error;

  vx_raster_tbuf_writer #(
    .INSTANCE_ID  ("tb"),
    .TILE_LOGSIZE (5),
    .ADDR_W       (ADDR_W)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .start         (start),
    .tbuf_addr     (tbuf_addr),
    .max_tiles     (max_tiles),
    .flush         (flush),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .in_sop        (in_sop),
    .in_eop        (in_eop),
    .in_xloc       (in_xloc),
    .in_yloc       (in_yloc),
    .in_pid        (in_pid),
    .mem_req_valid (mem_req_valid),
    .mem_req_ready (mem_req_ready),
    .mem_req_addr  (mem_req_addr),
    .mem_req_data  (mem_req_data),
    .busy          (busy),
    .done          (done),
    .tile_count    (tile_count),
    .error         (error)
  );

  always #5 clk = ~clk;

  int          n_checks = 0;
  int          n_fail   = 0;
  logic [31:0] exp_addr_q[$];
  logic [31:0] exp_data_q[$];
  logic [31:0] stall_q[$];
  bit          mon_ignore = 1'b0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, got, exp, $time);
    end
  endtask

  task automatic expect_wr(input logic [31:0] addr, input logic [31:0] data);
    exp_addr_q.push_back(addr);
    exp_data_q.push_back(data);
  endtask

  // Monitor: every accepted write must match the scoreboard head; stalled requests must hold.
  initial begin
    bit          pend = 1'b0;
    logic [31:0] pend_addr, pend_data, ea, ed;
    forever begin
      @(negedge clk);
      if (mon_ignore || !reset) begin
        pend = 1'b0;
      end else begin
        if (pend) begin
          check("hold_valid", 32'(mem_req_valid), 32'd1);
          check("hold_addr", 32'(mem_req_addr), pend_addr);
          check("hold_data", mem_req_data, pend_data);
        end
        pend = 1'b0;
        if (mem_req_valid && mem_req_ready) begin
          if (exp_addr_q.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL unexpected_write: got addr 0x%08h data 0x%08h, expected none",
                     32'(mem_req_addr), mem_req_data);
          end else begin
            ea = exp_addr_q.pop_front();
            ed = exp_data_q.pop_front();
            check("wr_addr", 32'(mem_req_addr), ea);
            check("wr_data", mem_req_data, ed);
          end
        end else if (mem_req_valid) begin
          pend      = 1'b1;
          pend_addr = 32'(mem_req_addr);
          pend_data = mem_req_data;
        end
      end
    end
  end

  // Memory back-pressure: drop ready for 5 cycles when a listed address first appears.
  initial begin
    mem_req_ready = 1'b1;
    forever begin
      @(posedge clk);
      #2;
      if (stall_q.size() != 0 && mem_req_valid && 32'(mem_req_addr) == stall_q[0]) begin
        void'(stall_q.pop_front());
        mem_req_ready = 1'b0;
        repeat (5) begin
          @(negedge clk);
          check("stall_in_ready", 32'(in_ready), 32'd0);
          @(posedge clk);
          #2;
        end
        mem_req_ready = 1'b1;
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout, expected test completion");
    $fatal(1, "watchdog expired");
  end

  // All driver tasks start and end at 1 time unit after a rising edge.
  task automatic do_start(input logic [ADDR_W-1:0] addr, input logic [15:0] mt);
    start     = 1'b1;
    tbuf_addr = addr;
    max_tiles = mt;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  task automatic send_pid(input logic sop, input logic eop, input logic [15:0] x,
                          input logic [15:0] y, input logic [31:0] pid);
    bit acc = 1'b0;
    in_valid = 1'b1;
    in_sop   = sop;
    in_eop   = eop;
    in_xloc  = x;
    in_yloc  = y;
    in_pid   = pid;
    for (int n = 0; n < 100 && !acc; n++) begin
      @(negedge clk);
      acc = in_ready;
      @(posedge clk);
      #1;
    end
    check("pid_accepted", 32'(acc), 32'd1);
    in_valid = 1'b0;
    in_sop   = 1'b0;
    in_eop   = 1'b0;
  endtask

  task automatic finish_frame(input logic [15:0] tc, input logic err);
    bit seen = 1'b0;
    flush = 1'b1;
    for (int n = 0; n < 200 && !seen; n++) begin
      @(negedge clk);
      seen = done;
      if (seen) begin
        check("tile_count", 32'(tile_count), 32'(tc));
        check("error", 32'(error), 32'(err));
        check("writes_left", exp_addr_q.size(), 32'd0);
      end
      @(posedge clk);
      #1;
    end
    flush = 1'b0;
    check("done_seen", 32'(seen), 32'd1);
    @(negedge clk);
    check("idle_busy", 32'(busy), 32'd0);
    check("done_pulse", 32'(done), 32'd0);
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset     = 1'b0;
    start     = 1'b0;
    tbuf_addr = '0;
    max_tiles = '0;
    flush     = 1'b0;
    in_valid  = 1'b0;
    in_sop    = 1'b0;
    in_eop    = 1'b0;
    in_xloc   = '0;
    in_yloc   = '0;
    in_pid    = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_mem_valid", 32'(mem_req_valid), 32'd0);
    check("rst_in_ready", 32'(in_ready), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_tile_count", 32'(tile_count), 32'd0);
    check("rst_error", 32'(error), 32'd0);
    @(posedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk);
    #1;

    // Single tile at (64,32): PID base 0x108, header (y=1,x=2), offset 6 count 3.
    expect_wr(32'h108, 32'd7);
    expect_wr(32'h109, 32'd9);
    expect_wr(32'h10A, 32'd4);
    expect_wr(32'h100, 32'h0001_0002);
    expect_wr(32'h101, 32'h0003_0006);
    do_start(30'h100, 16'd4);
    send_pid(1'b1, 1'b0, 16'd64, 16'd32, 32'd7);
    send_pid(1'b0, 1'b0, 16'd64, 16'd32, 32'd9);
    send_pid(1'b0, 1'b1, 16'd64, 16'd32, 32'd4);
    finish_frame(16'd1, 1'b0);

    // Two tiles; second is a single sop=eop PID at (96,0).
    expect_wr(32'h108, 32'd7);
    expect_wr(32'h109, 32'd9);
    expect_wr(32'h10A, 32'd4);
    expect_wr(32'h100, 32'h0001_0002);
    expect_wr(32'h101, 32'h0003_0006);
    expect_wr(32'h10B, 32'h55);
    expect_wr(32'h102, 32'h0000_0003);
    expect_wr(32'h103, 32'h0001_0007);
    do_start(30'h100, 16'd4);
    send_pid(1'b1, 1'b0, 16'd64, 16'd32, 32'd7);
    send_pid(1'b0, 1'b0, 16'd64, 16'd32, 32'd9);
    send_pid(1'b0, 1'b1, 16'd64, 16'd32, 32'd4);
    send_pid(1'b1, 1'b1, 16'd96, 16'd0, 32'h55);
    finish_frame(16'd2, 1'b0);

    // Back-pressure mid-PID (0x305) and mid-HDR1 (0x301).
    stall_q.push_back(32'h305);
    stall_q.push_back(32'h301);
    expect_wr(32'h304, 32'hA0);
    expect_wr(32'h305, 32'hA1);
    expect_wr(32'h306, 32'hA2);
    expect_wr(32'h300, 32'h0000_0000);
    expect_wr(32'h301, 32'h0003_0002);
    do_start(30'h300, 16'd2);
    send_pid(1'b1, 1'b0, 16'd0, 16'd0, 32'hA0);
    send_pid(1'b0, 1'b0, 16'd0, 16'd0, 32'hA1);
    send_pid(1'b0, 1'b1, 16'd0, 16'd0, 32'hA2);
    finish_frame(16'd1, 1'b0);
    check("stalls_consumed", stall_q.size(), 32'd0);

    // max_tiles=1 with two tiles.
    expect_wr(32'h202, 32'h11);
    expect_wr(32'h203, 32'h12);
    expect_wr(32'h200, 32'h0001_0001);
    expect_wr(32'h201, 32'h0002_0000);
`ifndef RASTER_TBUF_OVF_CHECK_EN
    expect_wr(32'h204, 32'h13);
    expect_wr(32'h202, 32'h0002_0000);
    expect_wr(32'h203, 32'h0001_0000);
`endif
    do_start(30'h200, 16'd1);
    send_pid(1'b1, 1'b0, 16'd32, 16'd32, 32'h11);
    send_pid(1'b0, 1'b1, 16'd32, 16'd32, 32'h12);
    send_pid(1'b1, 1'b1, 16'd0, 16'd64, 32'h13);
`ifdef RASTER_TBUF_OVF_CHECK_EN
    finish_frame(16'd1, 1'b1);
`else
    finish_frame(16'd2, 1'b0);
`endif

    // Reset while the header is being written, then a clean frame.
    mon_ignore = 1'b1;
    do_start(30'h100, 16'd4);
    send_pid(1'b1, 1'b1, 16'd0, 16'd0, 32'h77);
    reset = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check("mid_rst_mem_valid", 32'(mem_req_valid), 32'd0);
    check("mid_rst_in_ready", 32'(in_ready), 32'd0);
    check("mid_rst_busy", 32'(busy), 32'd0);
    check("mid_rst_done", 32'(done), 32'd0);
    check("mid_rst_tile_count", 32'(tile_count), 32'd0);
    check("mid_rst_error", 32'(error), 32'd0);
    @(posedge clk);
    #1;
    reset = 1'b1;
    exp_addr_q.delete();
    exp_data_q.delete();
    @(posedge clk);
    #1;
    mon_ignore = 1'b0;
    expect_wr(32'h408, 32'd7);
    expect_wr(32'h400, 32'h0001_0002);
    expect_wr(32'h401, 32'h0001_0006);
    do_start(30'h400, 16'd4);
    send_pid(1'b1, 1'b1, 16'd64, 16'd32, 32'd7);
    finish_frame(16'd1, 1'b0);

    // Empty frame: flush right away, done two cycles after start, no writes.
    flush = 1'b1;
    do_start(30'h500, 16'd4);
    @(negedge clk);
    check("empty_busy", 32'(busy), 32'd1);
    check("empty_done_early", 32'(done), 32'd0);
    @(posedge clk);
    #1;
    @(negedge clk);
    check("empty_done", 32'(done), 32'd1);
    check("empty_tile_count", 32'(tile_count), 32'd0);
    @(posedge clk);
    #1;
    flush = 1'b0;
    @(negedge clk);
    check("empty_done_pulse", 32'(done), 32'd0);
    check("empty_idle", 32'(busy), 32'd0);
    check("empty_no_writes", exp_addr_q.size(), 32'd0);

    repeat (3) @(posedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
